// File: rtl/fpu_pkg.sv
// fpu_pkg: shared types, constants and helpers for the binary32 arithmetic unit
package fpu_pkg;
  typedef enum logic [2:0] {OP_ADD = 3'b000, OP_SUB = 3'b001, OP_MUL = 3'b010} op_e;
  typedef enum logic [1:0] {IDLE, UNPACK, COMPUTE, ROUND} state_e;
  localparam int EXP_BIAS = 127;
  localparam logic [31:0] CANON_NAN = 32'h7FC00000;
  localparam logic [31:0] POS_INF = 32'h7F800000;
  typedef struct packed {
    logic        sign;
    logic [9:0]  exp;
    logic [23:0] mant;
    logic        is_zero;
    logic        is_inf;
    logic        is_nan;
  } ufloat_t;
  // Subnormals get effective exponent 1 and no hidden bit, so {exp, mant} orders by magnitude
  function automatic ufloat_t unpack(input logic [31:0] x);
    ufloat_t u;
    u.sign = x[31];
    u.exp = |x[30:23] ? {2'b0, x[30:23]} : 10'd1;
    u.mant = {|x[30:23], x[22:0]};
    u.is_zero = x[30:0] == 31'd0;
    u.is_inf = &x[30:23] && x[22:0] == 23'd0;
    u.is_nan = &x[30:23] && |x[22:0];
    return u;
  endfunction
  function automatic logic [5:0] lzc48(input logic [47:0] v);
    logic [5:0] n;
    n = 6'd48;
    for (int i = 0; i < 48; i++) if (v[i]) n = 6'(47 - i);
    return n;
  endfunction
endpackage

// File: rtl/fpu_round_pack.sv
// fpu_round_pack: round-to-nearest-even and binary32 packing of a normalized value
module fpu_round_pack (
  input  logic               sign,
  input  logic signed [11:0] exp,
  input  logic [23:0]        mant,
  input  logic               g,
  input  logic               r,
  input  logic               s,
  output logic [31:0]        res
);
  logic [24:0] sum;
  logic signed [11:0] e;
  // exp is 1 with mant[23]=0 for subnormals; a rounding carry into bit 23 promotes naturally
  always_comb begin
    sum = {1'b0, mant} + {24'b0, g & (r | s | mant[0])};
    e = sum[24] ? exp + 12'sd1 : exp;
    res = e >= 12'sd255 ? {sign, 8'hFF, 23'b0}
      : {sign, sum[24] | sum[23] ? e[7:0] : 8'h00, sum[24] ? sum[23:1] : sum[22:0]};
  end
endmodule

// File: rtl/fpu_wrapper.sv
// fpu_wrapper: multi-cycle binary32 add/sub/mul with RNE rounding and a start/done handshake
module fpu_wrapper
  import fpu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  done
);
  state_e state, state_d;
  logic ld_op, ld_un, ld_cp, fin;
  logic [DATA_WIDTH-1:0] a_q, b_q;
  logic [2:0] op_q;
  ufloat_t ua, ub;
  logic swap, xs, ys, as;
  logic [9:0] xe, ye, d, nsh;
  logic [23:0] xm, ym;
  logic [4:0] ash;
  logic [50:0] ysh;
  logic [26:0] y27, an;
  logic [27:0] sum;
  logic [5:0] alz, mlz, lsh;
  logic signed [11:0] ae, e0, mel, me;
  logic [47:0] p;
  logic [6:0] rsh;
  logic [95:0] mrs;
  logic is_mul, bad_op, any_inf, any_zero, spec;
  logic [31:0] spec_val;
  logic c_sign, c_g, c_r, c_s, c_spec;
  logic signed [11:0] c_exp;
  logic [23:0] c_mant;
  logic [31:0] c_val, rp_res;
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_d;
  // The done cycle is already IDLE, so start is masked there to keep it ignored
  always_comb
    state_d = state == IDLE ? (start && !done ? UNPACK : IDLE)
      : state == UNPACK ? COMPUTE : state == COMPUTE ? ROUND : IDLE;
  always_comb begin
    ld_op = state == IDLE && start && !done;
    ld_un = state == UNPACK;
    ld_cp = state == COMPUTE;
    fin = state == ROUND;
  end
  // Add/sub: larger magnitude in x, y aligned with sticky, then leading-zero normalize
  always_comb begin
    swap = {ub.exp, ub.mant} > {ua.exp, ua.mant};
    xs = swap ? ub.sign : ua.sign;
    xe = swap ? ub.exp : ua.exp;
    xm = swap ? ub.mant : ua.mant;
    ys = swap ? ua.sign : ub.sign;
    ye = swap ? ua.exp : ub.exp;
    ym = swap ? ua.mant : ub.mant;
    d = xe - ye;
    ash = d > 10'd27 ? 5'd27 : d[4:0];
    ysh = {ym, 27'b0} >> ash;
    y27 = {ysh[50:25], ysh[24] | (|ysh[23:0])};
    sum = xs == ys ? {1'b0, xm, 3'b0} + {1'b0, y27} : {1'b0, xm, 3'b0} - {1'b0, y27};
    alz = lzc48({sum[26:0], 21'b0});
    nsh = {4'b0, alz} < xe - 10'd1 ? {4'b0, alz} : xe - 10'd1;
    an = sum[27] ? {sum[27:2], sum[1] | sum[0]} : sum[26:0] << nsh;
    ae = sum[27] ? 12'(xe) + 12'sd1 : 12'(xe - nsh);
    as = sum == 28'd0 ? xs & ys : xs;
  end
  // Mul: normalize the product left, or right into the subnormal range when e0 < 1
  always_comb begin
    p = 48'(ua.mant) * 48'(ub.mant);
    mlz = lzc48(p);
    e0 = $signed(12'(ua.exp)) + $signed(12'(ub.exp)) - $signed(12'(EXP_BIAS - 1));
    mel = e0 - $signed({6'b0, mlz});
    lsh = mel >= 12'sd1 ? mlz : e0 >= 12'sd1 ? 6'(e0 - 12'sd1) : 6'd0;
    rsh = e0 >= 12'sd1 ? 7'd0 : 12'sd1 - e0 > 12'sd60 ? 7'd60 : 7'(12'sd1 - e0);
    mrs = {p << lsh, 48'b0} >> rsh;
    me = mel >= 12'sd1 ? mel : 12'sd1;
  end
  always_comb begin
    is_mul = op_q == OP_MUL;
    bad_op = !(is_mul || op_q == OP_ADD || op_q == OP_SUB);
    any_inf = ua.is_inf | ub.is_inf;
    any_zero = ua.is_zero | ub.is_zero;
    spec = bad_op | ua.is_nan | ub.is_nan | any_inf | (is_mul & any_zero);
    spec_val = bad_op | ua.is_nan | ub.is_nan ? CANON_NAN
      : is_mul ? (any_inf & any_zero ? CANON_NAN : {ua.sign ^ ub.sign, any_inf ? POS_INF[30:0] : 31'b0})
      : ua.is_inf & ub.is_inf & (ua.sign ^ ub.sign) ? CANON_NAN
      : {ua.is_inf ? ua.sign : ub.sign, POS_INF[30:0]};
  end
  fpu_round_pack u_round_pack (
    .sign(c_sign),
    .exp (c_exp),
    .mant(c_mant),
    .g   (c_g),
    .r   (c_r),
    .s   (c_s),
    .res (rp_res)
  );
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      a_q <= '0;
      b_q <= '0;
      op_q <= '0;
      ua <= '0;
      ub <= '0;
      c_sign <= 1'b0;
      c_exp <= '0;
      c_mant <= '0;
      c_g <= 1'b0;
      c_r <= 1'b0;
      c_s <= 1'b0;
      c_spec <= 1'b0;
      c_val <= '0;
      result <= '0;
      done <= 1'b0;
    end else begin
      done <= fin;
      if (ld_op) begin
        a_q <= a;
        b_q <= b;
        op_q <= op;
      end
      if (ld_un) begin
        ua <= unpack(a_q);
        ub <= unpack(b_q ^ {op_q == OP_SUB, 31'b0});
      end
      if (ld_cp) begin
        c_sign <= is_mul ? ua.sign ^ ub.sign : as;
        c_exp <= is_mul ? me : ae;
        c_mant <= is_mul ? mrs[95:72] : an[26:3];
        c_g <= is_mul ? mrs[71] : an[2];
        c_r <= is_mul ? mrs[70] : an[1];
        c_s <= is_mul ? |mrs[69:0] : an[0];
        c_spec <= spec;
        c_val <= spec_val;
      end
      if (fin) result <= c_spec ? c_val : rp_res;
    end
endmodule

// File: tb/tb_fpu_wrapper.sv
// tb_fpu_wrapper: directed vector table plus handshake/reset sequences for fpu_wrapper
module tb_fpu_wrapper;
  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;
  logic clock, reset, start, done;
  logic [2:0] op;
  logic [31:0] a, b, result;
  int applied, miscompares;
  vec_t vecs[20];
  fpu_wrapper #(.DATA_WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .result(result),
    .done  (done)
  );
  initial clock = 1'b0;
  always #5 clock = ~clock;
  task automatic check(input string nm, input int id, input logic [31:0] got, input logic [31:0] want);
    applied++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s #%0d: got %h expected %h", nm, id, got, want);
    end
  endtask
  task automatic run(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input logic [31:0] e, input int id);
    int k;
    @(negedge clock);
    op = o;
    a = x;
    b = y;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    a = ~x;
    b = ~y;
    k = 1;
    while (!done && k < 10) begin
      @(negedge clock);
      k++;
    end
    check("latency", id, 32'(k - 1), 32'd3);
    check("result", id, result, e);
    @(negedge clock);
    check("done_pulse", id, {31'b0, done}, 32'd0);
    check("result_hold", id, result, e);
  endtask
  initial begin
    int dn;
    applied = 0;
    miscompares = 0;
    vecs[0]  = '{3'b000, 32'h3F800000, 32'h40000000, 32'h40400000};
    vecs[1]  = '{3'b010, 32'h3FC00000, 32'h40000000, 32'h40400000};
    vecs[2]  = '{3'b001, 32'h3F800000, 32'h3F800000, 32'h00000000};
    vecs[3]  = '{3'b000, 32'h3F800000, 32'h33800000, 32'h3F800000};
    vecs[4]  = '{3'b000, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000};
    vecs[5]  = '{3'b000, 32'h00000001, 32'h00000001, 32'h00000002};
    vecs[6]  = '{3'b010, 32'h00800000, 32'h3F000000, 32'h00400000};
    vecs[7]  = '{3'b000, 32'h7F800000, 32'hFF800000, 32'h7FC00000};
    vecs[8]  = '{3'b010, 32'h00000000, 32'h7F800000, 32'h7FC00000};
    vecs[9]  = '{3'b000, 32'h7FC00001, 32'h3F800000, 32'h7FC00000};
    vecs[10] = '{3'b111, 32'h3F800000, 32'h3F800000, 32'h7FC00000};
    vecs[11] = '{3'b000, 32'h80000000, 32'h80000000, 32'h80000000};
    vecs[12] = '{3'b001, 32'h40000000, 32'h3F800000, 32'h3F800000};
    vecs[13] = '{3'b000, 32'h3F800000, 32'hB3800000, 32'h3F7FFFFF};
    vecs[14] = '{3'b000, 32'h3F800001, 32'h33800000, 32'h3F800002};
    vecs[15] = '{3'b010, 32'h7F7FFFFF, 32'h40000000, 32'h7F800000};
    vecs[16] = '{3'b001, 32'h7F800000, 32'h7F800000, 32'h7FC00000};
    vecs[17] = '{3'b010, 32'hC0000000, 32'h7F800000, 32'hFF800000};
    vecs[18] = '{3'b010, 32'h00000003, 32'h3F000000, 32'h00000002};
    vecs[19] = '{3'b010, 32'h00000001, 32'h3F000000, 32'h00000000};
    reset = 1'b0;
    start = 1'b1;
    op = 3'b000;
    a = 32'h3F800000;
    b = 32'h40000000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("reset_result", i, result, 32'h00000000);
      check("reset_done", i, {31'b0, done}, 32'd0);
    end
    start = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 20; i++) run(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, i);
    // Second start one cycle after acceptance, and another during the done cycle, are ignored
    @(negedge clock);
    op = 3'b000;
    a = 32'h3F800000;
    b = 32'h40000000;
    start = 1'b1;
    @(negedge clock);
    op = 3'b010;
    a = 32'h40000000;
    b = 32'h40000000;
    @(negedge clock);
    start = 1'b0;
    dn = 2;
    while (!done && dn < 10) begin
      @(negedge clock);
      dn++;
    end
    check("ignore_latency", 100, 32'(dn - 1), 32'd3);
    check("ignore_result", 100, result, 32'h40400000);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    dn = 0;
    repeat (8) begin
      @(negedge clock);
      dn += int'(done);
    end
    check("ignore_extra_done", 100, 32'(dn), 32'd0);
    check("ignore_hold", 100, result, 32'h40400000);
    // Reset during an operation aborts it without a done
    @(negedge clock);
    op = 3'b010;
    a = 32'h3FC00000;
    b = 32'h40000000;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("abort_result", 200, result, 32'h00000000);
    check("abort_done", 200, {31'b0, done}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    dn = 0;
    repeat (6) begin
      @(negedge clock);
      dn += int'(done);
    end
    check("abort_no_done", 200, 32'(dn), 32'd0);
    check("abort_result_after", 200, result, 32'h00000000);
    run(3'b010, 32'h40000000, 32'h40000000, 32'h40800000, 201);
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule
